// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Optional two's-complement input: the magnitude is converted and the sign
// is reported separately. Digits beyond NUM_DIGITS are dropped; a sticky
// flag records that the magnitude did not fit.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready=1
// SHIFT | double-dabble in progress, BIN_WIDTH cycles; busy=1
// DONE  | result held on bcd_out/sign_out/overflow until out_ready

module binary_to_bcd_seq #(
    parameter int BIN_WIDTH   = 32,
    parameter int NUM_DIGITS  = 10,
    parameter int SIGNED_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_DIGITS*4-1:0] bcd_out,
    output logic                    sign_out,
    output logic                    overflow,
    output logic                    busy
);

    localparam int BCD_W = NUM_DIGITS * 4;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [BIN_WIDTH-1:0] work_bin;
    logic [BCD_W-1:0]     work_bcd;
    logic                 work_sign;
    logic                 work_ovf;
    logic [CNT_W-1:0]     bit_cnt;

    logic                 accept;
    logic                 last_shift;
    logic                 in_neg;
    logic [BIN_WIDTH-1:0] operand;
    logic [BCD_W-1:0]     adj_bcd;
    logic [BCD_W-1:0]     shift_bcd;
    logic                 shift_carry;

    assign accept     = (state == IDLE) && in_valid;
    assign last_shift = (state == SHIFT) && (bit_cnt == CNT_W'(1));
    assign in_neg     = (SIGNED_MODE != 0) && bin_in[BIN_WIDTH-1];

    // Magnitude of the incoming operand; the most negative value maps to
    // 2^(BIN_WIDTH-1), which is still exact as an unsigned BIN_WIDTH word.
    always_comb begin
        operand = bin_in;
        if (in_neg) begin
            operand = ~bin_in + {{(BIN_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // One double-dabble step: +3 on digits >= 5, then shift in the next
    // operand bit. The bit leaving the top digit is the overflow carry.
    always_comb begin
        adj_bcd = work_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (work_bcd[i*4 +: 4] >= 4'd5) begin
                adj_bcd[i*4 +: 4] = work_bcd[i*4 +: 4] + 4'd3;
            end
        end
        {shift_carry, shift_bcd} = {adj_bcd, work_bin[BIN_WIDTH-1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_shift) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Working registers: load on accept, step once per SHIFT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_bin  <= '0;
            work_bcd  <= '0;
            work_sign <= 1'b0;
            work_ovf  <= 1'b0;
            bit_cnt   <= '0;
        end else if (accept) begin
            work_bin  <= operand;
            work_bcd  <= '0;
            work_sign <= in_neg;
            work_ovf  <= 1'b0;
            bit_cnt   <= CNT_W'(BIN_WIDTH);
        end else if (state == SHIFT) begin
            work_bin  <= {work_bin[BIN_WIDTH-2:0], 1'b0};
            work_bcd  <= shift_bcd;
            work_ovf  <= work_ovf | shift_carry;
            bit_cnt   <= bit_cnt - CNT_W'(1);
        end
    end

    // Result registers capture the final step and hold until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_out  <= '0;
            sign_out <= 1'b0;
            overflow <= 1'b0;
        end else if (last_shift) begin
            bcd_out  <= shift_bcd;
            sign_out <= work_sign;
            overflow <= work_ovf | shift_carry;
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq. Three instances share one stimulus:
// defaults, a 3-digit unsigned variant and a signed variant, so every
// conversion is checked against all three configurations at once.

module tb_binary_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] bin_in = '0;
    logic        out_ready = 1'b0;

    logic        d0_in_ready, d0_out_valid, d0_sign, d0_ovf, d0_busy;
    logic [39:0] d0_bcd;
    logic        d3_in_ready, d3_out_valid, d3_sign, d3_ovf, d3_busy;
    logic [11:0] d3_bcd;
    logic        ds_in_ready, ds_out_valid, ds_sign, ds_ovf, ds_busy;
    logic [39:0] ds_bcd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    binary_to_bcd_seq #(.BIN_WIDTH(32), .NUM_DIGITS(10), .SIGNED_MODE(0)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d0_in_ready),
        .bin_in(bin_in), .out_valid(d0_out_valid), .out_ready(out_ready),
        .bcd_out(d0_bcd), .sign_out(d0_sign), .overflow(d0_ovf), .busy(d0_busy)
    );

    binary_to_bcd_seq #(.BIN_WIDTH(32), .NUM_DIGITS(3), .SIGNED_MODE(0)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d3_in_ready),
        .bin_in(bin_in), .out_valid(d3_out_valid), .out_ready(out_ready),
        .bcd_out(d3_bcd), .sign_out(d3_sign), .overflow(d3_ovf), .busy(d3_busy)
    );

    binary_to_bcd_seq #(.BIN_WIDTH(32), .NUM_DIGITS(10), .SIGNED_MODE(1)) u_ds (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ds_in_ready),
        .bin_in(bin_in), .out_valid(ds_out_valid), .out_ready(out_ready),
        .bcd_out(ds_bcd), .sign_out(ds_sign), .overflow(ds_ovf), .busy(ds_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " d0 hs"},  {d0_in_ready, d0_out_valid, d0_busy}, 3'b100);
        chk({tag, " d0 res"}, {d0_bcd, d0_sign, d0_ovf}, '0);
        chk({tag, " d3 hs"},  {d3_in_ready, d3_out_valid, d3_busy}, 3'b100);
        chk({tag, " d3 res"}, {d3_bcd, d3_sign, d3_ovf}, '0);
        chk({tag, " ds hs"},  {ds_in_ready, ds_out_valid, ds_busy}, 3'b100);
        chk({tag, " ds res"}, {ds_bcd, ds_sign, ds_ovf}, '0);
    endtask

    // Full conversion: accept at the next posedge, measure latency, check
    // all three results, hold DONE for 'hold' cycles, then release.
    task automatic convert(input string tag, input logic [31:0] v, input int hold,
                           input logic release_rst,
                           input logic [39:0] e0_bcd, input logic e0_ovf,
                           input logic [11:0] e3_bcd, input logic e3_ovf,
                           input logic [39:0] es_bcd, input logic es_sign, input logic es_ovf);
        int lat;
        int busy_n;
        @(negedge clk);
        if (release_rst) rst = 1'b1;
        bin_in    = v;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk({tag, " in_ready"}, d0_in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!d0_out_valid && lat < 40) begin
            if (d0_busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, 32);
        chk({tag, " busy cycles"}, busy_n, 32);
        chk({tag, " done hs"}, {d0_in_ready, d0_busy, d3_out_valid, ds_out_valid}, 4'b0011);
        chk({tag, " d0 bcd"}, d0_bcd, e0_bcd);
        chk({tag, " d0 sign/ovf"}, {d0_sign, d0_ovf}, {1'b0, e0_ovf});
        chk({tag, " d3 bcd"}, d3_bcd, e3_bcd);
        chk({tag, " d3 sign/ovf"}, {d3_sign, d3_ovf}, {1'b0, e3_ovf});
        chk({tag, " ds bcd"}, ds_bcd, es_bcd);
        chk({tag, " ds sign/ovf"}, {ds_sign, ds_ovf}, {es_sign, es_ovf});
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            bin_in   = $urandom;
            @(posedge clk); #1;
            chk({tag, " hold state"}, {d0_out_valid, d0_in_ready, d0_busy}, 3'b100);
            chk({tag, " hold result"}, {d0_bcd, d0_ovf, d3_bcd, d3_ovf}, {e0_bcd, e0_ovf, e3_bcd, e3_ovf});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " release"}, {d0_out_valid, d0_in_ready}, 2'b01);
        chk({tag, " kept result"}, {d0_bcd, d3_bcd, ds_bcd, ds_sign}, {e0_bcd, e3_bcd, es_bcd, es_sign});
    endtask

    initial begin
        int c;
        int idx;
        int nres;
        int run;
        int last;
        logic [31:0] b2b_vals [3];
        logic [39:0] b2b_exp [3];
        b2b_vals = '{32'd0, 32'd1, 32'd100};
        b2b_exp  = '{40'h0, 40'h1, 40'h100};

        #23;
        chk_reset_outputs("reset");

        // Basic conversion; also first accept straight after reset release.
        convert("dec11", 32'h0000_000B, 0, 1'b1,
                40'h11, 1'b0, 12'h011, 1'b0, 40'h11, 1'b0, 1'b0);
        convert("dec999", 32'd999, 0, 1'b0,
                40'h999, 1'b0, 12'h999, 1'b0, 40'h999, 1'b0, 1'b0);
        convert("dec1000", 32'd1000, 0, 1'b0,
                40'h1000, 1'b0, 12'h000, 1'b1, 40'h1000, 1'b0, 1'b0);
        convert("all_ones", 32'hFFFF_FFFF, 0, 1'b0,
                40'h4294967295, 1'b0, 12'h295, 1'b1, 40'h1, 1'b1, 1'b0);
        convert("min_neg", 32'h8000_0000, 0, 1'b0,
                40'h2147483648, 1'b0, 12'h648, 1'b1, 40'h2147483648, 1'b1, 1'b0);
        convert("backpressure", 32'd12345, 20, 1'b0,
                40'h12345, 1'b0, 12'h345, 1'b1, 40'h12345, 1'b0, 1'b0);

        // Reset in the middle of SHIFT, with no clock edge before checking.
        @(negedge clk);
        bin_in   = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("pre-reset busy", d0_busy, 1'b1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid-shift reset");
        convert("after reset", 32'h0000_000B, 0, 1'b1,
                40'h11, 1'b0, 12'h011, 1'b0, 40'h11, 1'b0, 1'b0);

        // Back-to-back stream with in_valid and out_ready held high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        c = 0; idx = 0; nres = 0; run = 0; last = -1;
        while (nres < 3 && c < 200) begin
            if (d0_in_ready) begin
                if (idx < 3) begin
                    bin_in = b2b_vals[idx];
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            c++;
            if (d0_busy) begin
                run++;
            end else if (run != 0) begin
                chk("b2b busy run", run, 32);
                run = 0;
            end
            if (d0_out_valid) begin
                chk("b2b result", d0_bcd, b2b_exp[nres]);
                if (last >= 0) chk("b2b spacing", c - last, 34);
                last = c;
                nres++;
            end
        end
        chk("b2b result count", nres, 3);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/binary_to_bcd_seq.md
BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Interface
REQ-001 SHALL have parameter BIN_WIDTH, default 32, binary input width (legal range >= 2).
REQ-002 SHALL have parameter NUM_DIGITS, default 10, number of BCD output digits (legal range >= 1).
REQ-003 SHALL have parameter SIGNED_MODE, default 0; 0 = unsigned input, 1 = two's-complement input.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  bin_in holds a value to convert.
REQ-007 SHALL have port in_ready  output  1  block accepts a new value.
REQ-008 SHALL have port bin_in  input  BIN_WIDTH  binary value.
REQ-009 SHALL have port out_valid  output  1  result ports hold a completed conversion.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port bcd_out  output  NUM_DIGITS*4  packed BCD digits; digit 0 (units) in bits [3:0].
REQ-012 SHALL have port sign_out  output  1  input was negative (SIGNED_MODE=1 only; otherwise 0).
REQ-013 SHALL have port overflow  output  1  magnitude exceeded 10^NUM_DIGITS-1.
REQ-014 SHALL have port busy  output  1  conversion in progress.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; the state is IDLE after reset.
REQ-016 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in SHIFT; out_valid SHALL be 1 only in DONE.
REQ-017 Accept SHALL occur on an edge with in_valid=1 and in_ready=1; the block latches the operand and moves IDLE->SHIFT; the BCD working register clears to 0 and the bit counter loads BIN_WIDTH.
REQ-018 With SIGNED_MODE=1 and bin_in MSB=1, the latched operand SHALL be the two's-complement magnitude (BIN_WIDTH-bit unsigned, so -2^(BIN_WIDTH-1) is exact) and the sign flag SHALL be 1; otherwise the operand is bin_in and the sign flag is 0.
REQ-019 Each SHIFT edge SHALL add 3 to every working digit >= 5, then shift {digits, operand} left by 1 bit, and decrement the counter; this is double-dabble, one bit per cycle.
REQ-020 A sticky overflow flag SHALL set when the bit shifted out of the top digit is 1; it clears on accept.
REQ-021 bcd_out SHALL equal magnitude mod 10^NUM_DIGITS, including when overflow is set.
REQ-022 On the edge where the counter reaches 0 (the BIN_WIDTH-th edge after accept), the FSM SHALL move SHIFT->DONE, and bcd_out, sign_out and overflow SHALL load from the working state.
REQ-023 Latency SHALL be exactly BIN_WIDTH clock cycles from the accept edge to out_valid=1, independent of SIGNED_MODE and value.
REQ-024 DONE SHALL hold out_valid and the results stable until an edge with out_ready=1, then move DONE->IDLE; in_ready rises in the following cycle; maximum throughput is one result per BIN_WIDTH+2 cycles.
REQ-025 bcd_out, sign_out and overflow SHALL hold their last values after leaving DONE until the next completion.
REQ-026 in_valid and bin_in changes SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.

Reset
REQ-027 rst=0 SHALL, asynchronously and at any state including mid-SHIFT, force state IDLE and zero the working registers; outputs SHALL read in_ready=1, out_valid=0, busy=0, bcd_out=0, sign_out=0, overflow=0.
REQ-028 After rst returns to 1, the first accept SHALL be possible on the first rising edge.

Verification
REQ-029 Defaults, bin_in=0x0000000B, accept, out_ready=1 -> out_valid exactly 32 cycles after accept; bcd_out=...0011 (decimal 11); sign_out=0; overflow=0.
REQ-030 NUM_DIGITS=3, bin_in=999 -> bcd_out=0x999, overflow=0; then bin_in=1000 -> bcd_out=0x000, overflow=1; then bin_in=4294967295 -> bcd_out=0x295, overflow=1.
REQ-031 SIGNED_MODE=1, bin_in=0xFFFFFFFF -> sign_out=1, bcd_out=1. Then bin_in=0x80000000 -> sign_out=1, bcd_out=2147483648, overflow=0.
REQ-032 Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid, bcd_out and overflow stable and in_ready=0; in_valid pulses are ignored. Raise out_ready -> IDLE on next edge.
REQ-033 Assert rst=0 at 10 cycles into SHIFT -> all outputs are at reset values immediately, without waiting for clk. Release rst, convert 0x0B -> correct result at exact latency.
REQ-034 Back-to-back: keep in_valid=1 and out_ready=1 with values 0, 1, 100 -> three results in order, one every 34 cycles; busy high for exactly 32 cycles each.
